// File: rtl/main_memory_ram_if.sv
// CPU memory bus between a requester and main_memory_ram.
// The RD/WR request is held until ACK, and ERR is only meaningful while ACK=1.
interface main_memory_ram_if #(
    parameter int DATAWIDTH_BUS = 32
) ();
    logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_RAM_ADDRESS_data_InBUS;
    logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_RAM_data_InBUS;
    logic                     MAIN_MEMORY_RAM_RD_data_In;
    logic                     MAIN_MEMORY_RAM_WR_data_In;
    logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_RAM_data_OutBUS;
    logic                     MAIN_MEMORY_RAM_ACK;
    logic                     MAIN_MEMORY_RAM_ERR;
    logic                     MAIN_MEMORY_RAM_BUSY;

    modport master (
        output MAIN_MEMORY_RAM_ADDRESS_data_InBUS, MAIN_MEMORY_RAM_data_InBUS,
               MAIN_MEMORY_RAM_RD_data_In, MAIN_MEMORY_RAM_WR_data_In,
        input  MAIN_MEMORY_RAM_data_OutBUS, MAIN_MEMORY_RAM_ACK,
               MAIN_MEMORY_RAM_ERR, MAIN_MEMORY_RAM_BUSY
    );

    modport slave (
        input  MAIN_MEMORY_RAM_ADDRESS_data_InBUS, MAIN_MEMORY_RAM_data_InBUS,
               MAIN_MEMORY_RAM_RD_data_In, MAIN_MEMORY_RAM_WR_data_In,
        output MAIN_MEMORY_RAM_data_OutBUS, MAIN_MEMORY_RAM_ACK,
               MAIN_MEMORY_RAM_ERR, MAIN_MEMORY_RAM_BUSY
    );
endinterface

// File: rtl/main_memory_ram.sv
// Word-addressed CPU main memory with request/ACK handshake and wait states.
// Defining MAIN_MEMORY_RAM_ALIGN_CHECK_EN turns misaligned accesses into errors.
//
// state  | meaning
// IDLE   | waiting for RD/WR; request is latched on acceptance
// WAIT   | counting wait states down to zero
// DONE   | access performed on entry; ACK (and ERR) high for this cycle
module main_memory_ram #(
    parameter int                 DATAWIDTH_BUS = 32,
    parameter int                 DEPTH         = 1024,
    parameter logic [DATAWIDTH_BUS-1:0] BASE_ADDR = 'h0000_0800,
    parameter int                 WAIT_STATES   = 1
) (
    input  logic              MAIN_MEMORY_RAM_CLOCK_50,
    input  logic              MAIN_MEMORY_RAM_RESET_InHigh,
    main_memory_ram_if.slave  bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [DATAWIDTH_BUS-1:0] LIMIT = DATAWIDTH_BUS'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     op_wr_q, op_wr_d;
    logic                     err_q, err_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
    logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH];

    logic [DATAWIDTH_BUS-1:0] offset;
    logic                     in_range;
    logic                     misaligned;
    logic                     finishing;
    logic                     mem_we;

    // Offset compare avoids overflow of BASE_ADDR + 4*DEPTH near the top of the map.
    assign offset   = bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS - BASE_ADDR;
    assign in_range = (bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS >= BASE_ADDR) && (offset < LIMIT);
`ifdef MAIN_MEMORY_RAM_ALIGN_CHECK_EN
    assign misaligned = (bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign finishing = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = finishing && op_wr_q && !err_q && !MAIN_MEMORY_RAM_RESET_InHigh;

    always_ff @(posedge MAIN_MEMORY_RAM_CLOCK_50) begin
        if (MAIN_MEMORY_RAM_RESET_InHigh) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge MAIN_MEMORY_RAM_CLOCK_50) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.MAIN_MEMORY_RAM_WR_data_In || bus.MAIN_MEMORY_RAM_RD_data_In) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                    op_wr_d = bus.MAIN_MEMORY_RAM_WR_data_In;
                    err_d   = !in_range || misaligned;
                    idx_d   = offset[IDXW+1:2];
                    wdata_d = bus.MAIN_MEMORY_RAM_data_InBUS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!op_wr_q) begin
                        rdata_d = err_q ? '0 : mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.MAIN_MEMORY_RAM_ACK         = (state_q == S_DONE);
        bus.MAIN_MEMORY_RAM_ERR         = (state_q == S_DONE) && err_q;
        bus.MAIN_MEMORY_RAM_BUSY        = (state_q != S_IDLE);
        bus.MAIN_MEMORY_RAM_data_OutBUS = rdata_q;
    end
endmodule

// File: tb/tb_main_memory_ram.sv
// Directed bench for main_memory_ram: handshake timing, read/write, range errors, reset abort.
module tb_main_memory_ram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_memory_ram_if #(.DATAWIDTH_BUS(32)) bus ();
    main_memory_ram_if #(.DATAWIDTH_BUS(32)) bus0 ();
    main_memory_ram_if #(.DATAWIDTH_BUS(32)) bus3 ();

    main_memory_ram #(.DATAWIDTH_BUS(32), .DEPTH(1024), .BASE_ADDR(32'h800), .WAIT_STATES(1)) u_dut (
        .MAIN_MEMORY_RAM_CLOCK_50(clk), .MAIN_MEMORY_RAM_RESET_InHigh(rst), .bus(bus));
    main_memory_ram #(.DATAWIDTH_BUS(32), .DEPTH(1024), .BASE_ADDR(32'h800), .WAIT_STATES(0)) u_ws0 (
        .MAIN_MEMORY_RAM_CLOCK_50(clk), .MAIN_MEMORY_RAM_RESET_InHigh(rst), .bus(bus0));
    main_memory_ram #(.DATAWIDTH_BUS(32), .DEPTH(1024), .BASE_ADDR(32'h800), .WAIT_STATES(3)) u_ws3 (
        .MAIN_MEMORY_RAM_CLOCK_50(clk), .MAIN_MEMORY_RAM_RESET_InHigh(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;

    int          lat;
    int          busy_cyc;
    logic        err_s;
    logic [31:0] data_s;
    logic        ack_after;
    logic        busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_STATES=1 instance; lat is edges after the sampling edge.
    task automatic access(input logic is_wr, input logic is_rd, input logic [31:0] addr,
                          input logic [31:0] data);
        @(negedge clk);
        bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = addr;
        bus.MAIN_MEMORY_RAM_data_InBUS         = data;
        bus.MAIN_MEMORY_RAM_WR_data_In         = is_wr;
        bus.MAIN_MEMORY_RAM_RD_data_In         = is_rd;
        @(posedge clk);
        #1;
        bus.MAIN_MEMORY_RAM_WR_data_In = 1'b0;
        bus.MAIN_MEMORY_RAM_RD_data_In = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        err_s    = 1'bx;
        data_s   = 'x;
        for (int j = 0; j < 20; j++) begin
            if (bus.MAIN_MEMORY_RAM_BUSY) busy_cyc++;
            if (bus.MAIN_MEMORY_RAM_ACK) begin
                lat    = j;
                err_s  = bus.MAIN_MEMORY_RAM_ERR;
                data_s = bus.MAIN_MEMORY_RAM_data_OutBUS;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        ack_after  = bus.MAIN_MEMORY_RAM_ACK;
        busy_after = bus.MAIN_MEMORY_RAM_BUSY;
    endtask

    initial begin
        int acks;
        int l0, l3, n0, n3;

        rst = 1'b1;
        bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS  = '0;
        bus.MAIN_MEMORY_RAM_data_InBUS          = '0;
        bus.MAIN_MEMORY_RAM_RD_data_In          = 1'b0;
        bus.MAIN_MEMORY_RAM_WR_data_In          = 1'b0;
        bus0.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = 32'h800;
        bus0.MAIN_MEMORY_RAM_data_InBUS         = '0;
        bus0.MAIN_MEMORY_RAM_RD_data_In         = 1'b0;
        bus0.MAIN_MEMORY_RAM_WR_data_In         = 1'b0;
        bus3.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = 32'h800;
        bus3.MAIN_MEMORY_RAM_data_InBUS         = '0;
        bus3.MAIN_MEMORY_RAM_RD_data_In         = 1'b0;
        bus3.MAIN_MEMORY_RAM_WR_data_In         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",  {31'd0, bus.MAIN_MEMORY_RAM_ACK},  32'd0);
        check("rst_err",  {31'd0, bus.MAIN_MEMORY_RAM_ERR},  32'd0);
        check("rst_busy", {31'd0, bus.MAIN_MEMORY_RAM_BUSY}, 32'd0);
        check("rst_data", bus.MAIN_MEMORY_RAM_data_OutBUS,   32'd0);
        rst = 1'b0;

        // First read after reset: timing and BUSY envelope.
        access(1'b0, 1'b1, 32'h800, 32'h0);
        check("rd0_lat",        lat,                    32'd2);
        check("rd0_err",        {31'd0, err_s},         32'd0);
        check("rd0_busy_cyc",   busy_cyc,               32'd3);
        check("rd0_ack_after",  {31'd0, ack_after},     32'd0);
        check("rd0_busy_after", {31'd0, busy_after},    32'd0);

        access(1'b1, 1'b0, 32'h804, 32'hDEADBEEF);
        check("wr804_lat", lat,            32'd2);
        check("wr804_err", {31'd0, err_s}, 32'd0);
        access(1'b0, 1'b1, 32'h804, 32'h0);
        check("rd804_data", data_s, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h808, 32'h11111111);
        check("wr808_hold", data_s, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'h800, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h17FC, 32'h0BADCAFE);
        check("wr_last_err", {31'd0, err_s}, 32'd0);
        access(1'b0, 1'b1, 32'h17FC, 32'h0);
        check("rd_last_data", data_s, 32'h0BADCAFE);

        // Out-of-range accesses on both sides of the window.
        access(1'b0, 1'b1, 32'h7FC, 32'h0);
        check("rd7fc_lat",  lat,            32'd2);
        check("rd7fc_err",  {31'd0, err_s}, 32'd1);
        check("rd7fc_data", data_s,         32'd0);
        access(1'b0, 1'b1, 32'h804, 32'h0);
        access(1'b0, 1'b1, 32'h1800, 32'h0);
        check("rd1800_err",  {31'd0, err_s}, 32'd1);
        check("rd1800_data", data_s,         32'd0);
        access(1'b0, 1'b1, 32'h804, 32'h0);
        access(1'b1, 1'b0, 32'h1800, 32'h1);
        check("wr1800_err",  {31'd0, err_s}, 32'd1);
        check("wr1800_hold", data_s,         32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h800, 32'h0);
        check("rd800_intact", data_s, 32'hCAFEF00D);

        // RD+WR together, held through WAIT; address/data changed after acceptance.
        @(negedge clk);
        bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = 32'h810;
        bus.MAIN_MEMORY_RAM_data_InBUS         = 32'h12345678;
        bus.MAIN_MEMORY_RAM_RD_data_In         = 1'b1;
        bus.MAIN_MEMORY_RAM_WR_data_In         = 1'b1;
        @(posedge clk);
        #1;
        bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = 32'h804;
        bus.MAIN_MEMORY_RAM_data_InBUS         = 32'hFFFFFFFF;
        acks = 0;
        for (int j = 0; j < 6; j++) begin
            if (bus.MAIN_MEMORY_RAM_ACK) begin
                acks++;
                bus.MAIN_MEMORY_RAM_RD_data_In = 1'b0;
                bus.MAIN_MEMORY_RAM_WR_data_In = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("rdwr_ack_count", acks, 32'd1);
        access(1'b0, 1'b1, 32'h810, 32'h0);
        check("rd810_data", data_s, 32'h12345678);
        access(1'b0, 1'b1, 32'h804, 32'h0);
        check("rd804_untouched", data_s, 32'hDEADBEEF);

        // Reset during WAIT aborts a pending write.
        access(1'b1, 1'b0, 32'h820, 32'h0F0F0F0F);
        @(negedge clk);
        bus.MAIN_MEMORY_RAM_ADDRESS_data_InBUS = 32'h820;
        bus.MAIN_MEMORY_RAM_data_InBUS         = 32'hA5A5A5A5;
        bus.MAIN_MEMORY_RAM_WR_data_In         = 1'b1;
        @(posedge clk);
        #1;
        bus.MAIN_MEMORY_RAM_WR_data_In = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.MAIN_MEMORY_RAM_BUSY}, 32'd0);
        acks = 0;
        for (int j = 0; j < 4; j++) begin
            if (bus.MAIN_MEMORY_RAM_ACK) acks++;
            @(posedge clk);
            #1;
        end
        check("abort_no_ack", acks, 32'd0);
        access(1'b0, 1'b1, 32'h820, 32'h0);
        check("rd820_prior", data_s, 32'h0F0F0F0F);

        access(1'b0, 1'b1, 32'h802, 32'h0);
`ifdef MAIN_MEMORY_RAM_ALIGN_CHECK_EN
        check("rd802_err",  {31'd0, err_s}, 32'd1);
        check("rd802_data", data_s,         32'd0);
`else
        check("rd802_err",  {31'd0, err_s}, 32'd0);
        check("rd802_data", data_s,         32'hCAFEF00D);
`endif

        // Latency of the WAIT_STATES=0 and =3 instances.
        @(negedge clk);
        bus0.MAIN_MEMORY_RAM_RD_data_In = 1'b1;
        bus3.MAIN_MEMORY_RAM_RD_data_In = 1'b1;
        @(posedge clk);
        #1;
        bus0.MAIN_MEMORY_RAM_RD_data_In = 1'b0;
        bus3.MAIN_MEMORY_RAM_RD_data_In = 1'b0;
        l0 = -1; l3 = -1; n0 = 0; n3 = 0;
        for (int j = 0; j < 10; j++) begin
            if (bus0.MAIN_MEMORY_RAM_ACK) begin
                n0++;
                if (l0 < 0) l0 = j;
            end
            if (bus3.MAIN_MEMORY_RAM_ACK) begin
                n3++;
                if (l3 < 0) l3 = j;
            end
            @(posedge clk);
            #1;
        end
        check("ws0_lat",  l0, 32'd1);
        check("ws0_acks", n0, 32'd1);
        check("ws3_lat",  l3, 32'd4);
        check("ws3_acks", n3, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
